jump_control_unit: RTL and testbench

//   Hardwired control sequencer driving the existing Datapath control inputs: fetch plus execute for br, jr, jal, nop, halt.

---
 rtl/jump_control_unit.sv | 169 ++++++++++++++++
 tb/tb_jump_control_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jump_control_unit.sv
// Hardwired fetch/execute sequencer for br, jr, jal, nop and halt, driving the Datapath control inputs.
// One state per clk edge; controls are decoded from the state register (plus mem_rdy/con_ff/ir where noted).
module jump_control_unit #(
  parameter logic [4:0] OP_BR       = 5'b10010,
  parameter logic [4:0] OP_JR       = 5'b10011,
  parameter logic [4:0] OP_JAL      = 5'b10100,
  parameter logic [4:0] OP_NOP      = 5'b11001,
  parameter logic [4:0] OP_HALT     = 5'b11010,
  parameter logic [4:0] ALU_ADD     = 5'b00011,
  parameter int         LINK_REG    = 8,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_rdy,
  output logic        PC_out,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDR_out,
  output logic        Read,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_out,
  output logic        Rin,
  output logic        BAout,
  output logic        CONin,
  output logic        Yin,
  output logic        C_out,
  output logic        Zlowin,
  output logic        Zlo_out,
  output logic [4:0]  op_sel,
  output logic [15:0] R_rd,
  output logic        run,
  output logic        illegal_op,
  output logic        mem_fault
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC, S_JR_A, S_JAL_A, S_JAL_B,
    S_BR_A, S_BR_B, S_BR_C, S_BR_D, S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [4:0]       opcode;
  logic             timeout;
  logic             unused_ir_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign opcode         = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];
  // Fault fires on the MEM_TIMEOUT-th consecutive F1 cycle without data.
  assign timeout = (state == S_F1) && !mem_rdy && (wait_cnt >= CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_RST;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_F1 && !mem_rdy)
        wait_cnt <= sat_inc(wait_cnt);
      else
        wait_cnt <= '0;
      if (timeout)
        mem_fault <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    PC_out     = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDR_out    = 1'b0;
    Read       = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    R_out      = 1'b0;
    Rin        = 1'b0;
    BAout      = 1'b0;
    CONin      = 1'b0;
    Yin        = 1'b0;
    C_out      = 1'b0;
    Zlowin     = 1'b0;
    Zlo_out    = 1'b0;
    op_sel     = 5'b0;
    R_rd       = 16'b0;
    illegal_op = 1'b0;
    run        = (state != S_RST) && (state != S_HALT);
    case (state)
      S_RST: state_nxt = S_F0;
      S_F0: begin
        PC_out = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_nxt = S_F1;
      end
      S_F1: begin
        // PC is only reloaded from Z on the cycle the fetch completes.
        Zlo_out = 1'b1; Read = 1'b1; MDRin = 1'b1;
        PCin    = mem_rdy;
        if (mem_rdy)      state_nxt = S_F2;
        else if (timeout) state_nxt = S_HALT;
      end
      S_F2: begin
        MDR_out = 1'b1; IRin = 1'b1;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        if (opcode == OP_BR)        state_nxt = S_BR_A;
        else if (opcode == OP_JR)   state_nxt = S_JR_A;
        else if (opcode == OP_JAL)  state_nxt = S_JAL_A;
        else if (opcode == OP_NOP)  state_nxt = S_F0;
        else if (opcode == OP_HALT) state_nxt = S_HALT;
        else begin
          illegal_op = 1'b1;
          state_nxt  = S_F0;
        end
      end
      S_JR_A: begin
        Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
        state_nxt = S_F0;
      end
      S_JAL_A: begin
        PC_out = 1'b1; Rin = 1'b1;
        R_rd   = 16'b1 << LINK_REG;
        state_nxt = S_JAL_B;
      end
      S_JAL_B: begin
        Gra = 1'b1; R_out = 1'b1; PCin = 1'b1;
        state_nxt = S_F0;
      end
      S_BR_A: begin
        Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
        state_nxt = S_BR_B;
      end
      S_BR_B: begin
        PC_out = 1'b1; Yin = 1'b1;
        state_nxt = S_BR_C;
      end
      S_BR_C: begin
        C_out = 1'b1; Zlowin = 1'b1; op_sel = ALU_ADD;
        state_nxt = S_BR_D;
      end
      S_BR_D: begin
        Zlo_out = 1'b1; PCin = con_ff;
        state_nxt = S_F0;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_jump_control_unit.sv
// Table-driven bench for jump_control_unit: each row is one clock cycle of inputs and the outputs expected in it.
// Expected outputs are queued when a row is driven and compared on the following falling edge.
module tb_jump_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        con_ff;
  logic        mem_rdy;
  logic        PC_out, PCin, IncPC, MARin, MDRin, MDR_out, Read, IRin;
  logic        Gra, Grb, Grc, R_out, Rin, BAout, CONin, Yin, C_out;
  logic        Zlowin, Zlo_out, run, illegal_op, mem_fault;
  logic [4:0]  op_sel;
  logic [15:0] R_rd;

  always #5 clk = ~clk;

  jump_control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_rdy(mem_rdy),
    .PC_out(PC_out), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDR_out(MDR_out), .Read(Read), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_out(R_out), .Rin(Rin), .BAout(BAout),
    .CONin(CONin), .Yin(Yin), .C_out(C_out),
    .Zlowin(Zlowin), .Zlo_out(Zlo_out), .op_sel(op_sel), .R_rd(R_rd),
    .run(run), .illegal_op(illegal_op), .mem_fault(mem_fault)
  );

  // Control bit masks, in the order the monitor concatenates the outputs.
  localparam logic [21:0] PCO = 22'h1 << 21, PCI = 22'h1 << 20, INC = 22'h1 << 19, MAR = 22'h1 << 18;
  localparam logic [21:0] MDI = 22'h1 << 17, MDO = 22'h1 << 16, RD  = 22'h1 << 15, IRI = 22'h1 << 14;
  localparam logic [21:0] GRA = 22'h1 << 13, RO  = 22'h1 << 10, RIN = 22'h1 << 9;
  localparam logic [21:0] CON = 22'h1 << 7,  YIN = 22'h1 << 6,  CO  = 22'h1 << 5;
  localparam logic [21:0] ZLI = 22'h1 << 4,  ZLO = 22'h1 << 3,  RUN = 22'h1 << 2, ILL = 22'h1 << 1, MF = 22'h1;

  localparam logic [21:0] E_F0   = PCO | MAR | INC | ZLI | RUN;
  localparam logic [21:0] E_F1W  = ZLO | RD | MDI | RUN;
  localparam logic [21:0] E_F1   = E_F1W | PCI;
  localparam logic [21:0] E_F2   = MDO | IRI | RUN;
  localparam logic [21:0] E_DEC  = RUN;
  localparam logic [21:0] E_JR   = GRA | RO | PCI | RUN;
  localparam logic [21:0] E_JALA = PCO | RIN | RUN;
  localparam logic [21:0] E_BRA  = GRA | RO | CON | RUN;
  localparam logic [21:0] E_BRB  = PCO | YIN | RUN;
  localparam logic [21:0] E_BRC  = CO | ZLI | RUN;
  localparam logic [21:0] E_BRD  = ZLO | RUN;

  localparam logic [31:0] I_BR   = 32'h9000_0000;
  localparam logic [31:0] I_JR   = 32'h9800_0000;
  localparam logic [31:0] I_JAL  = 32'hA280_0000;
  localparam logic [31:0] I_NOP  = 32'hC800_0000;
  localparam logic [31:0] I_HALT = 32'hD000_0000;
  localparam logic [31:0] I_ILL  = 32'hF800_0000;

  typedef struct {
    string       nm;
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic        rdy;
    logic [42:0] exp;
  } vec_t;

  typedef struct {
    string       nm;
    logic [42:0] exp;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  logic [31:0] cur_ir;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void add(input string nm, input logic [21:0] ctrl, input logic rdy = 1'b1,
                              input logic con = 1'b0, input logic c = 1'b0,
                              input logic [4:0] op = 5'd0, input logic [15:0] rrd = 16'd0);
    vec_t v;
    v.nm  = nm;
    v.clr = c;
    v.ir  = cur_ir;
    v.con = con;
    v.rdy = rdy;
    v.exp = {ctrl, op, rrd};
    tbl.push_back(v);
  endfunction

  always @(negedge clk) begin
    logic [42:0] act;
    sb_t         it;
    if (sb.size() != 0) begin
      it  = sb.pop_front();
      act = {PC_out, PCin, IncPC, MARin, MDRin, MDR_out, Read, IRin,
             Gra, Grb, Grc, R_out, Rin, BAout, CONin, Yin, C_out,
             Zlowin, Zlo_out, run, illegal_op, mem_fault, op_sel, R_rd};
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h (t=%0t)", it.nm, act, it.exp, $time);
      end
    end
  end

  initial begin
    clr = 1'b1; ir = I_NOP; con_ff = 1'b0; mem_rdy = 1'b0;

    // Reset, then release: RST holds one more cycle, fetch follows.
    cur_ir = I_NOP;
    add("rst0", 22'h0, 1'b0, 1'b0, 1'b1);
    add("rst1", 22'h0, 1'b0, 1'b0, 1'b1);
    add("rst_rel", 22'h0, 1'b0);
    add("f0_first", E_F0);
    // jal R5 with the link register forced to R8
    cur_ir = I_JAL;
    add("jal_f1", E_F1); add("jal_f2", E_F2); add("jal_dec", E_DEC);
    add("jal_a", E_JALA, 1'b1, 1'b0, 1'b0, 5'd0, 16'h0100);
    add("jal_b", E_JR);
    cur_ir = I_NOP;
    add("nop_f0", E_F0); add("nop_f1", E_F1); add("nop_f2", E_F2); add("nop_dec", E_DEC);
    // br taken: con_ff only matters in BR_D
    cur_ir = I_BR;
    add("brt_f0", E_F0); add("brt_f1", E_F1); add("brt_f2", E_F2); add("brt_dec", E_DEC);
    add("brt_a", E_BRA); add("brt_b", E_BRB);
    add("brt_c", E_BRC, 1'b1, 1'b0, 1'b0, 5'b00011);
    add("brt_d", E_BRD | PCI, 1'b1, 1'b1);
    // br not taken, with con_ff high everywhere except BR_D
    add("brn_f0", E_F0, 1'b1, 1'b1); add("brn_f1", E_F1, 1'b1, 1'b1);
    add("brn_f2", E_F2, 1'b1, 1'b1); add("brn_dec", E_DEC, 1'b1, 1'b1);
    add("brn_a", E_BRA, 1'b1, 1'b1); add("brn_b", E_BRB, 1'b1, 1'b1);
    add("brn_c", E_BRC, 1'b1, 1'b1, 1'b0, 5'b00011);
    add("brn_d", E_BRD, 1'b1, 1'b0);
    // jr with two memory wait cycles in F1
    cur_ir = I_JR;
    add("jr_f0", E_F0); add("jr_f1w0", E_F1W, 1'b0); add("jr_f1w1", E_F1W, 1'b0);
    add("jr_f1", E_F1); add("jr_f2", E_F2); add("jr_dec", E_DEC); add("jr_a", E_JR);
    // unsupported opcode: one-cycle illegal_op, then fetch again
    cur_ir = I_ILL;
    add("ill_f0", E_F0); add("ill_f1", E_F1); add("ill_f2", E_F2);
    add("ill_dec", E_DEC | ILL); add("ill_next", E_F0);
    // br aborted by clr in BR_C: no PCin afterwards
    cur_ir = I_BR;
    add("abt_f1", E_F1); add("abt_f2", E_F2); add("abt_dec", E_DEC);
    add("abt_a", E_BRA, 1'b1, 1'b1); add("abt_b", E_BRB, 1'b1, 1'b1);
    add("abt_c", E_BRC, 1'b1, 1'b1, 1'b1, 5'b00011);
    add("abt_rst", 22'h0, 1'b1, 1'b1);
    add("abt_f0", E_F0, 1'b1, 1'b1);
    // halt: absorbing until clr
    cur_ir = I_HALT;
    add("hlt_f1", E_F1); add("hlt_f2", E_F2); add("hlt_dec", E_DEC);
    add("hlt_0", 22'h0); add("hlt_1", 22'h0, 1'b0); add("hlt_2", 22'h0, 1'b1, 1'b1);
    add("hlt_clr", 22'h0, 1'b1, 1'b0, 1'b1);
    add("hlt_rst", 22'h0); add("hlt_f0", E_F0);
    // fetch timeout: 15 F1 cycles without mem_rdy, then sticky fault in HALT
    cur_ir = I_NOP;
    for (int i = 0; i < 15; i++) add($sformatf("to_f1w%0d", i), E_F1W, 1'b0);
    add("to_halt0", MF); add("to_halt1", MF);
    add("to_clr", MF, 1'b1, 1'b0, 1'b1);
    add("to_rst", 22'h0); add("to_f0", E_F0);

    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      sb_t it;
      @(posedge clk);
      #1;
      clr     = tbl[i].clr;
      ir      = tbl[i].ir;
      con_ff  = tbl[i].con;
      mem_rdy = tbl[i].rdy;
      it.nm   = tbl[i].nm;
      it.exp  = tbl[i].exp;
      sb.push_back(it);
    end
    for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
